// File: rtl/enigma_seq_ctrl.sv
// Sequencer for the rotor/reflector cipher chain: loads the configuration, takes host
// characters, steps the rotors odometer-style and issues each letter with a completion timeout.
module enigma_seq_ctrl #(
   parameter int TIMEOUT    = 64,
   parameter int SET_CYCLES = 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       cfg_load,
   input  logic [4:0] cfg_pos1,
   input  logic [4:0] cfg_pos2,
   input  logic [4:0] cfg_pos3,
   input  logic [4:0] cfg_notch1,
   input  logic [4:0] cfg_notch2,
   input  logic [4:0] cfg_notch3,
   input  logic       in_valid,
   input  logic [7:0] in_char,
   output logic       in_ready,
   output logic       out_valid,
   output logic [7:0] out_char,
   input  logic       out_ready,
   output logic       busy,
   output logic       err_timeout,
   output logic       dp_set,
   output logic       dp_valid,
   output logic [7:0] dp_din,
   input  logic       dp_done,
   input  logic [7:0] dp_dout,
   output logic [4:0] pos1,
   output logic [4:0] pos2,
   output logic [4:0] pos3
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CONFIG = 3'd1;
   localparam logic [2:0] S_READY  = 3'd2;
   localparam logic [2:0] S_STEP   = 3'd3;
   localparam logic [2:0] S_ISSUE  = 3'd4;
   localparam logic [2:0] S_WAIT   = 3'd5;
   localparam logic [2:0] S_OUTPUT = 3'd6;

   localparam int SET_W = (SET_CYCLES > 1) ? $clog2(SET_CYCLES) : 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SET_CYCLES - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

   localparam logic [7:0] CHAR_ERR = 8'h3F;

   logic [2:0]       state;
   logic [2:0]       state_nxt;
   logic [4:0]       notch1;
   logic [4:0]       notch2;
   logic [7:0]       char_q;
   logic [SET_W-1:0] set_cnt;
   logic [TO_W-1:0]  to_cnt;

   logic cfg_start;
   logic accept;
   logic is_letter;
   logic set_last;
   logic to_last;
   logic carry1;
   logic carry2;
   logic unused_cfg;

   // Turnover position of the slowest rotor has no effect on stepping.
   assign unused_cfg = ^cfg_notch3;

   // Increment modulo 26; out-of-range configured values fold back into 0..25.
   function automatic logic [4:0] inc_mod26(input logic [4:0] p);
      return (p >= 5'd25) ? (p - 5'd25) : (p + 5'd1);
   endfunction

   // NOTE: in_ready is decoded combinationally so a cfg_load in READY withdraws it in the same cycle.
   assign in_ready    = (state == S_READY) && !cfg_load;
   assign out_valid   = (state == S_OUTPUT);
   assign dp_set      = (state == S_CONFIG);
   assign dp_valid    = (state == S_ISSUE);
   assign dp_din      = char_q;
   assign busy        = (state != S_IDLE) && (state != S_READY);

   assign cfg_start = cfg_load && ((state == S_IDLE) || (state == S_READY));
   assign accept    = in_valid && in_ready;
   assign is_letter = (in_char >= 8'h41) && (in_char <= 8'h5A);
   assign set_last  = (set_cnt == SET_LAST);
   assign to_last   = (to_cnt == TO_LAST);
   assign carry1    = (pos1 == notch1);
   assign carry2    = carry1 && (pos2 == notch2);

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (cfg_load) state_nxt = S_CONFIG;
         end
         S_CONFIG: begin
            if (set_last) state_nxt = S_READY;
         end
         S_READY: begin
            if (cfg_load)    state_nxt = S_CONFIG;
            else if (accept) state_nxt = is_letter ? S_STEP : S_OUTPUT;
         end
         S_STEP:  state_nxt = S_ISSUE;
         S_ISSUE: state_nxt = S_WAIT;
         S_WAIT: begin
            if (dp_done || to_last) state_nxt = S_OUTPUT;
         end
         S_OUTPUT: begin
            if (out_ready) state_nxt = S_READY;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: every register here uses non-blocking assignment so all state updates see pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                set_cnt <= '0;
      else if (state != S_CONFIG)  set_cnt <= '0;
      else                         set_cnt <= set_cnt + SET_W'(1);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               to_cnt <= '0;
      else if (state == S_ISSUE)  to_cnt <= '0;
      else if (state == S_WAIT)   to_cnt <= to_cnt + TO_W'(1);
   end

   // Rotor positions: loaded by configuration, stepped once per letter before it is issued.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pos1   <= '0;
         pos2   <= '0;
         pos3   <= '0;
         notch1 <= '0;
         notch2 <= '0;
      end else if (cfg_start) begin
         pos1   <= cfg_pos1;
         pos2   <= cfg_pos2;
         pos3   <= cfg_pos3;
         notch1 <= cfg_notch1;
         notch2 <= cfg_notch2;
      end else if (state == S_STEP) begin
         pos1 <= inc_mod26(pos1);
         if (carry1) pos2 <= inc_mod26(pos2);
         if (carry2) pos3 <= inc_mod26(pos3);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                   char_q <= '0;
      else if ((state == S_READY) && accept && is_letter
               && !cfg_load)                          char_q <= in_char;
   end

   // A completion arriving on the final timeout cycle is taken as a valid result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_char <= '0;
      end else if ((state == S_READY) && accept && !is_letter) begin
         out_char <= in_char;
      end else if (state == S_WAIT) begin
         if (dp_done)      out_char <= dp_dout;
         else if (to_last) out_char <= CHAR_ERR;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                   err_timeout <= 1'b0;
      else if (cfg_start)                             err_timeout <= 1'b0;
      else if ((state == S_WAIT) && !dp_done && to_last) err_timeout <= 1'b1;
   end

endmodule

// File: tb/tb_enigma_seq_ctrl.sv
// Directed bench for enigma_seq_ctrl: the host and the cipher chain are both driven from
// tasks on the falling edge, and outputs are sampled on the falling edge.
module tb_enigma_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       cfg_load = 1'b0;
   logic [4:0] cfg_pos1 = '0, cfg_pos2 = '0, cfg_pos3 = '0;
   logic [4:0] cfg_notch1 = '0, cfg_notch2 = '0, cfg_notch3 = '0;
   logic       in_valid = 1'b0;
   logic [7:0] in_char = '0;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_char;
   logic       out_ready = 1'b0;
   logic       busy;
   logic       err_timeout;
   logic       dp_set;
   logic       dp_valid;
   logic [7:0] dp_din;
   logic       dp_done = 1'b0;
   logic [7:0] dp_dout = '0;
   logic [4:0] pos1, pos2, pos3;

   int checks = 0;
   int errors = 0;
   int valid_cnt = 0;

   enigma_seq_ctrl #(.TIMEOUT(64), .SET_CYCLES(2)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load),
      .cfg_pos1(cfg_pos1), .cfg_pos2(cfg_pos2), .cfg_pos3(cfg_pos3),
      .cfg_notch1(cfg_notch1), .cfg_notch2(cfg_notch2), .cfg_notch3(cfg_notch3),
      .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready),
      .out_valid(out_valid), .out_char(out_char), .out_ready(out_ready),
      .busy(busy), .err_timeout(err_timeout),
      .dp_set(dp_set), .dp_valid(dp_valid), .dp_din(dp_din),
      .dp_done(dp_done), .dp_dout(dp_dout),
      .pos1(pos1), .pos2(pos2), .pos3(pos3)
   );

   always #5 clk = ~clk;

   // Counts issue strobes present during the cycle that ends at this edge.
   always @(posedge clk) if (dp_valid === 1'b1) valid_cnt++;

   task automatic do_cfg(input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] p3,
                         input logic [4:0] n1, input logic [4:0] n2);
      cfg_pos1 = p1; cfg_pos2 = p2; cfg_pos3 = p3;
      cfg_notch1 = n1; cfg_notch2 = n2; cfg_notch3 = 5'd0;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_char(input logic [7:0] ch);
      in_valid = 1'b1;
      in_char  = ch;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_dp_valid(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (dp_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL dp_valid_issue: got no strobe, expected one within 8 cycles");
      end
   endtask

   task automatic pulse_done(input logic [7:0] resp);
      dp_done = 1'b1;
      dp_dout = resp;
      @(negedge clk);
      dp_done = 1'b0;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, err_timeout, dp_set, dp_valid} !== 6'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {in_ready, out_valid, busy, err_timeout, dp_set, dp_valid});
      end
      checks++;
      if ({out_char, dp_din} !== 16'h0000) begin
         errors++; $display("FAIL reset_data: got %h expected 0000", {out_char, dp_din});
      end
      checks++;
      if ({pos1, pos2, pos3} !== 15'h0) begin
         errors++; $display("FAIL reset_pos: got %0d,%0d,%0d expected 0,0,0", pos1, pos2, pos3);
      end
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL idle_no_cfg: got in_ready=%b busy=%b expected 0 0", in_ready, busy);
      end
   endtask

   task automatic test_config();
      int set_cnt;
      cfg_pos1 = 5'd0; cfg_pos2 = 5'd0; cfg_pos3 = 5'd0;
      cfg_notch1 = 5'd16; cfg_notch2 = 5'd4; cfg_notch3 = 5'd0;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
      checks++;
      if (busy !== 1'b1) begin
         errors++; $display("FAIL config_busy: got %b expected 1", busy);
      end
      set_cnt = 0;
      repeat (6) begin
         if (dp_set === 1'b1) set_cnt++;
         @(negedge clk);
      end
      checks++;
      if (set_cnt != 2) begin
         errors++; $display("FAIL config_set_cycles: got %0d expected 2", set_cnt);
      end
      checks++;
      if (in_ready !== 1'b1 || {pos1, pos2, pos3} !== 15'h0) begin
         errors++;
         $display("FAIL config_ready: got in_ready=%b pos=%0d,%0d,%0d expected 1 pos=0,0,0",
                  in_ready, pos1, pos2, pos3);
      end
   endtask

   task automatic test_letter();
      int  v0;
      bit  seen;
      v0 = valid_cnt;
      send_char(8'h41);
      wait_dp_valid(seen);
      checks++;
      if ({pos1, pos2, pos3} !== {5'd1, 5'd0, 5'd0} || dp_din !== 8'h41) begin
         errors++;
         $display("FAIL letter_issue: got pos=%0d,%0d,%0d din=%h expected 1,0,0 din=41",
                  pos1, pos2, pos3, dp_din);
      end
      repeat (9) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b1) begin
         errors++; $display("FAIL letter_wait: got out_valid=%b busy=%b expected 0 1", out_valid, busy);
      end
      pulse_done(8'h42);
      checks++;
      if (out_valid !== 1'b1 || out_char !== 8'h42) begin
         errors++; $display("FAIL letter_result: got v=%b c=%h expected 1 42", out_valid, out_char);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_char !== 8'h42) begin
         errors++; $display("FAIL letter_hold: got v=%b c=%h expected 1 42", out_valid, out_char);
      end
      checks++;
      if (valid_cnt - v0 != 1) begin
         errors++; $display("FAIL letter_valid_pulses: got %0d expected 1", valid_cnt - v0);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL letter_return: got v=%b rdy=%b expected 0 1", out_valid, in_ready);
      end
   endtask

   task automatic test_double_carry();
      bit seen;
      do_cfg(5'd16, 5'd4, 5'd25, 5'd16, 5'd4);
      send_char(8'h42);
      wait_dp_valid(seen);
      checks++;
      if ({pos1, pos2, pos3} !== {5'd17, 5'd5, 5'd0}) begin
         errors++; $display("FAIL double_carry: got %0d,%0d,%0d expected 17,5,0", pos1, pos2, pos3);
      end
      @(negedge clk);
      pulse_done(8'h55);
      checks++;
      if (out_valid !== 1'b1 || out_char !== 8'h55) begin
         errors++; $display("FAIL double_carry_out: got v=%b c=%h expected 1 55", out_valid, out_char);
      end
      handshake();
   endtask

   task automatic test_wrap();
      bit seen;
      do_cfg(5'd25, 5'd7, 5'd3, 5'd3, 5'd4);
      send_char(8'h43);
      wait_dp_valid(seen);
      checks++;
      if ({pos1, pos2, pos3} !== {5'd0, 5'd7, 5'd3}) begin
         errors++; $display("FAIL pos1_wrap: got %0d,%0d,%0d expected 0,7,3", pos1, pos2, pos3);
      end
      @(negedge clk);
      pulse_done(8'h10);
      checks++;
      if (out_char !== 8'h10) begin
         errors++; $display("FAIL pos1_wrap_out: got %h expected 10", out_char);
      end
      handshake();
   endtask

   task automatic test_bypass();
      logic [7:0] bp [4];
      int v0;
      bp[0] = 8'h20; bp[1] = 8'h40; bp[2] = 8'h5B; bp[3] = 8'h61;
      for (int i = 0; i < 4; i++) begin
         v0 = valid_cnt;
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bypass_ready[%0d]: got %b expected 1", i, in_ready);
         end
         send_char(bp[i]);
         checks++;
         if (out_valid !== 1'b1 || out_char !== bp[i]) begin
            errors++;
            $display("FAIL bypass_out[%0d]: got v=%b c=%h expected 1 %h", i, out_valid, out_char, bp[i]);
         end
         checks++;
         if ({pos1, pos2, pos3} !== {5'd0, 5'd7, 5'd3} || valid_cnt != v0) begin
            errors++;
            $display("FAIL bypass_nostep[%0d]: got pos=%0d,%0d,%0d pulses=%0d expected 0,7,3 pulses=0",
                     i, pos1, pos2, pos3, valid_cnt - v0);
         end
         handshake();
      end
   endtask

   task automatic test_done_at_limit();
      bit seen;
      send_char(8'h5A);
      wait_dp_valid(seen);
      checks++;
      if ({pos1, pos2, pos3} !== {5'd1, 5'd7, 5'd3}) begin
         errors++; $display("FAIL z_step: got %0d,%0d,%0d expected 1,7,3", pos1, pos2, pos3);
      end
      repeat (64) @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL limit_still_wait: got out_valid=%b expected 0", out_valid);
      end
      pulse_done(8'h51);
      checks++;
      if (out_valid !== 1'b1 || out_char !== 8'h51 || err_timeout !== 1'b0) begin
         errors++;
         $display("FAIL limit_done_wins: got v=%b c=%h err=%b expected 1 51 0",
                  out_valid, out_char, err_timeout);
      end
      handshake();
   endtask

   task automatic test_timeout();
      bit seen;
      send_char(8'h45);
      wait_dp_valid(seen);
      repeat (64) @(negedge clk);
      checks++;
      if (err_timeout !== 1'b0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL timeout_early: got err=%b v=%b expected 0 0", err_timeout, out_valid);
      end
      @(negedge clk);
      checks++;
      if (err_timeout !== 1'b1 || out_valid !== 1'b1 || out_char !== 8'h3F) begin
         errors++;
         $display("FAIL timeout_abort: got err=%b v=%b c=%h expected 1 1 3f", err_timeout, out_valid, out_char);
      end
      pulse_done(8'h77);
      checks++;
      if (out_char !== 8'h3F) begin
         errors++; $display("FAIL late_done_output: got %h expected 3f", out_char);
      end
      handshake();
      pulse_done(8'h66);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || err_timeout !== 1'b1
          || out_char !== 8'h3F) begin
         errors++;
         $display("FAIL late_done_ready: got rdy=%b busy=%b v=%b err=%b c=%h expected 1 0 0 1 3f",
                  in_ready, busy, out_valid, err_timeout, out_char);
      end
      do_cfg(5'd3, 5'd3, 5'd3, 5'd16, 5'd4);
      checks++;
      if (err_timeout !== 1'b0 || {pos1, pos2, pos3} !== {5'd3, 5'd3, 5'd3}) begin
         errors++;
         $display("FAIL cfg_clears_err: got err=%b pos=%0d,%0d,%0d expected 0 3,3,3",
                  err_timeout, pos1, pos2, pos3);
      end
   endtask

   task automatic test_cfg_priority();
      int v0;
      v0 = valid_cnt;
      cfg_pos1 = 5'd9;
      cfg_load = 1'b1;
      in_valid = 1'b1;
      in_char  = 8'h4B;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
         errors++; $display("FAIL cfg_priority_ready: got %b expected 0", in_ready);
      end
      @(negedge clk);
      cfg_load = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (dp_set !== 1'b1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL cfg_priority_state: got set=%b v=%b expected 1 0", dp_set, out_valid);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || pos1 !== 5'd9 || valid_cnt != v0) begin
         errors++;
         $display("FAIL cfg_priority_drop: got rdy=%b pos1=%0d pulses=%0d expected 1 9 0",
                  in_ready, pos1, valid_cnt - v0);
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      send_char(8'h46);
      wait_dp_valid(seen);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || in_ready !== 1'b0 || {pos1, pos2, pos3} !== 15'h0 || dp_din !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid: got busy=%b rdy=%b pos=%0d,%0d,%0d din=%h expected 0 0 0,0,0 00",
                  busy, in_ready, pos1, pos2, pos3, dp_din);
      end
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL reset_needs_cfg: got rdy=%b busy=%b expected 0 0", in_ready, busy);
      end
   endtask

   initial begin
      test_reset();
      test_config();
      test_letter();
      test_double_carry();
      test_wrap();
      test_bypass();
      test_done_at_limit();
      test_timeout();
      test_cfg_priority();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
